// File: rtl/ip_ram_pkg.sv
// Shared constants for the ip_ram family: fill FSM encoding and legal read latencies.
package ip_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int unsigned RD_LAT_ONE = 1;
    localparam int unsigned RD_LAT_TWO = 2;

endpackage

// File: rtl/ip_ram_core.sv
// Storage array: one write port and one registered read port, no reset so it maps to block RAM.
module ip_ram_core #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Read-before-write: a same-edge write never leaks into the registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ip_ram_ex.sv
// Single-port RAM with bus access, zero-fill engine (on reset and on request),
// and a 1- or 2-cycle read pipeline whose outputs are zero outside read results.
module ip_ram_ex
    import ip_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 28,
    parameter int ADDR_WIDTH     = 12,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic                  bus_valid,
    output logic                  bus_ready,
    input  logic                  bus_write,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_rdata_en
);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nx;
    logic                  rd_acc, wr_acc;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  rd_v1;

    assign bus_ready = (state == ST_IDLE);
    assign busy      = (state == ST_CLEAR);
    assign rd_acc    = bus_valid & bus_ready & ~bus_write;
    assign wr_acc    = bus_valid & bus_ready & bus_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        core_we     = 1'b0;
        core_waddr  = bus_address;
        core_wdata  = bus_wdata;
        case (state)
            ST_IDLE: begin
                core_we = wr_acc;
                if (clear_req) begin
                    clr_addr_nx = '0;
                    state_nx    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                core_we     = 1'b1;
                core_waddr  = clr_addr;
                core_wdata  = '0;
                clr_addr_nx = clr_addr + 1'b1;
                if (clr_addr == '1) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    ip_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_acc),
        .raddr (bus_address),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_acc;
        end
    end

    // The core read register only updates on a new read, so fill writes cannot
    // disturb a result already in flight; the valid flag gates it to zero otherwise.
    if (READ_LATENCY == RD_LAT_TWO) begin : g_lat2
        logic                  rd_v2;
        logic [DATA_WIDTH-1:0] rdata2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_v2  <= 1'b0;
                rdata2 <= '0;
            end else begin
                rd_v2  <= rd_v1;
                rdata2 <= rd_v1 ? core_rdata : '0;
            end
        end

        assign bus_rdata_en = rd_v2;
        assign bus_rdata    = rdata2;
    end else begin : g_lat1
        assign bus_rdata_en = rd_v1;
        assign bus_rdata    = rd_v1 ? core_rdata : '0;
    end

endmodule

// File: tb/tb_ip_ram_ex.sv
// Bench for ip_ram_ex: latency-1 and latency-2 instances share stimulus and are
// checked against an array/countdown model of the RAM, fill engine and read timing.
module tb_ip_ram_ex;

    localparam int DW    = 28;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear_req = 1'b0;
    logic          bus_valid = 1'b0;
    logic          bus_write = 1'b0;
    logic [AW-1:0] bus_address = '0;
    logic [DW-1:0] bus_wdata = '0;

    logic          busy1, ready1, en1;
    logic [DW-1:0] rdata1;
    logic          busy2, ready2, en2;
    logic [DW-1:0] rdata2;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mdl_mem [DEPTH];
    int            fill_left = DEPTH;
    int            cyc = 0;
    logic [DW-1:0] exp1 [int];
    logic [DW-1:0] exp2 [int];

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    ip_ram_ex #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (1),
        .CLEAR_ON_RESET (1'b1)
    ) u_l1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_req    (clear_req),
        .busy         (busy1),
        .bus_address  (bus_address),
        .bus_valid    (bus_valid),
        .bus_ready    (ready1),
        .bus_write    (bus_write),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (rdata1),
        .bus_rdata_en (en1)
    );

    ip_ram_ex #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (2),
        .CLEAR_ON_RESET (1'b1)
    ) u_l2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_req    (clear_req),
        .busy         (busy2),
        .bus_address  (bus_address),
        .bus_valid    (bus_valid),
        .bus_ready    (ready2),
        .bus_write    (bus_write),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (rdata2),
        .bus_rdata_en (en2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        e1 = exp1.exists(cyc) ? exp1[cyc] : '0;
        e2 = exp2.exists(cyc) ? exp2[cyc] : '0;
        chk("busy_l1",     64'(busy1),  64'(fill_left > 0));
        chk("ready_l1",    64'(ready1), 64'(fill_left == 0));
        chk("rdata_en_l1", 64'(en1),    64'(exp1.exists(cyc)));
        chk("rdata_l1",    64'(rdata1), 64'(e1));
        chk("busy_l2",     64'(busy2),  64'(fill_left > 0));
        chk("ready_l2",    64'(ready2), 64'(fill_left == 0));
        chk("rdata_en_l2", 64'(en2),    64'(exp2.exists(cyc)));
        chk("rdata_l2",    64'(rdata2), 64'(e2));
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic c);
        bus_valid   = v;
        bus_write   = w;
        bus_address = a;
        bus_wdata   = d;
        clear_req   = c;
        @(posedge clk);
        if (v && fill_left == 0) begin
            if (w) begin
                mdl_mem[a] = d;
            end else begin
                exp1[cyc + 1] = mdl_mem[a];
                exp2[cyc + 2] = mdl_mem[a];
            end
        end
        if (fill_left > 0) begin
            mdl_mem[DEPTH - fill_left] = '0;
            fill_left--;
        end else if (c) begin
            fill_left = DEPTH;
        end
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        reset_n   = 1'b0;
        bus_valid = 1'b0;
        clear_req = 1'b0;
        exp1.delete();
        exp2.delete();
        fill_left = DEPTH;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_outputs();
        end
        reset_n = 1'b1;
    endtask

    // Count sampled busy cycles; optionally inject a clear_req or a write mid-fill.
    task automatic count_fill(output int n, input int clr_at, input int drop_at);
        n = 0;
        while (busy1 === 1'b1 && n < 40) begin
            n++;
            if (n == clr_at) step(1'b0, 1'b0, '0, '0, 1'b1);
            else if (n == drop_at) step(1'b1, 1'b1, 4'd7, 28'h0000777, 1'b0);
            else idle();
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 4'd5,  28'hABCDEF1, 28'hABCDEF1};
        tbl[1] = '{1'b1, 4'd0,  28'h0000001, 28'h0000001};
        tbl[2] = '{1'b1, 4'd15, 28'hFFFFFFF, 28'hFFFFFFF};
        tbl[3] = '{1'b1, 4'd10, 28'h5A5A5A5, 28'h5A5A5A5};
        tbl[4] = '{1'b0, 4'd5,  28'h0000000, 28'hABCDEF1};
        tbl[5] = '{1'b1, 4'd5,  28'h1234567, 28'h1234567};
        tbl[6] = '{1'b0, 4'd0,  28'h0000000, 28'h0000001};
        tbl[7] = '{1'b0, 4'd15, 28'h0000000, 28'hFFFFFFF};

        // Reset fill lasts exactly DEPTH cycles, then every word reads zero.
        @(negedge clk);
        do_reset(3);
        count_fill(n, 0, 0);
        chk("reset_fill_len", 64'(n), 64'd16);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 1'b0, AW'(a), '0, 1'b0);
            chk("post_fill_rd_en", 64'(en1), 64'd1);
            chk("post_fill_rd", 64'(rdata1), 64'd0);
        end
        idle();
        idle();

        // Table: optional write, then read; check both latencies against the table value.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) step(1'b1, 1'b1, tbl[i].addr, tbl[i].wdata, 1'b0);
            step(1'b1, 1'b0, tbl[i].addr, '0, 1'b0);
            chk("tbl_l1_en", 64'(en1), 64'd1);
            chk("tbl_l1_data", 64'(rdata1), 64'(tbl[i].exp));
            chk("tbl_l2_early", 64'(rdata2), 64'd0);
            idle();
            chk("tbl_l2_en", 64'(en2), 64'd1);
            chk("tbl_l2_data", 64'(rdata2), 64'(tbl[i].exp));
            chk("tbl_l1_after", 64'(rdata1), 64'd0);
        end
        idle();

        // Read then write to the same address on the next cycle.
        step(1'b1, 1'b1, 4'd3, 28'h1, 1'b0);
        step(1'b1, 1'b0, 4'd3, '0, 1'b0);
        chk("rw_hazard_l1", 64'(rdata1), 64'h1);
        step(1'b1, 1'b1, 4'd3, 28'h2, 1'b0);
        chk("rw_hazard_l2", 64'(rdata2), 64'h1);
        step(1'b1, 1'b0, 4'd3, '0, 1'b0);
        chk("rw_after_l1", 64'(rdata1), 64'h2);
        idle();
        chk("rw_after_l2", 64'(rdata2), 64'h2);

        // Read plus clear_req together; clear_req and a write during the fill are ignored.
        step(1'b1, 1'b1, 4'd7, 28'h55, 1'b0);
        step(1'b1, 1'b0, 4'd7, '0, 1'b1);
        chk("clr_rd_l1", 64'(rdata1), 64'h55);
        chk("clr_busy_rise", 64'(busy1), 64'd1);
        count_fill(n, 5, 12);
        chk("clr_fill_len", 64'(n), 64'd16);
        step(1'b1, 1'b0, 4'd7, '0, 1'b0);
        chk("clr_addr7_zero_en", 64'(en1), 64'd1);
        chk("clr_addr7_zero", 64'(rdata1), 64'd0);
        idle();

        // Reset pulsed in the middle of a fill restarts it from word 0.
        step(1'b1, 1'b0, 4'd10, '0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 9; i++) idle();
        chk("midfill_busy", 64'(busy1), 64'd1);
        do_reset(2);
        count_fill(n, 0, 0);
        chk("midfill_restart_len", 64'(n), 64'd16);

        // Random traffic with occasional clears, checked cycle by cycle by the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                 1'($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < 20; i++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ip_ram_ex.md
IP_RAM_EX -- requirements
Module: ip_ram_ex

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 28, meaning word width in bits (1..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, meaning cycles from accepted read to bus_rdata_en; legal values 1 or 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, meaning 1 = zero-fill all words after reset release, 0 = skip the fill.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear_req, input, 1, one-cycle request to zero-fill the whole RAM.
REQ-008 SHALL have port busy, output, 1, high while a zero-fill runs.
REQ-009 SHALL have port bus_address, input, ADDR_WIDTH, word address.
REQ-010 SHALL have port bus_valid, input, 1, access request.
REQ-011 SHALL have port bus_ready, output, 1, high when an access can be accepted.
REQ-012 SHALL have port bus_write, input, 1, 1 = write, 0 = read.
REQ-013 SHALL have port bus_wdata, input, DATA_WIDTH, write data.
REQ-014 SHALL have port bus_rdata, output, DATA_WIDTH, read data.
REQ-015 SHALL have port bus_rdata_en, output, 1, one-cycle strobe that marks bus_rdata as valid.

Function
REQ-016 SHALL implement a two-state FSM:
- ST_IDLE: accepts accesses.
- ST_CLEAR: writes zero to the word at clear counter clr_addr each cycle, then increments clr_addr.
REQ-017 SHALL drive bus_ready = (state == ST_IDLE) and busy = (state == ST_CLEAR), both combinationally from state.
REQ-018 SHALL accept an access only on a cycle with bus_valid & bus_ready; requests while bus_ready = 0 are dropped, not queued.
REQ-019 SHALL, on an accepted write, store bus_wdata at bus_address at that clock edge; no read strobe results.
REQ-020 SHALL, on an accepted read at cycle N, return the word as stored before edge N.
- READ_LATENCY=1: bus_rdata/bus_rdata_en valid in cycle N+1.
- READ_LATENCY=2: valid in cycle N+2 through one extra register stage.
REQ-021 SHALL hold bus_rdata at all-zero and bus_rdata_en at 0 in every cycle that carries no read result.
REQ-022 SHALL sustain one accepted access per cycle, including back-to-back reads, back-to-back writes and alternating read/write.
REQ-023 SHALL NOT let a write at N+1 to the same address alter the result of a read accepted at N.
REQ-024 SHALL, on clear_req = 1 in ST_IDLE, load clr_addr = 0 and enter ST_CLEAR next cycle; an access accepted in that same cycle still completes.
REQ-025 SHALL ignore clear_req while in ST_CLEAR; the fill does not restart.
REQ-026 SHALL leave ST_CLEAR for ST_IDLE on the edge that writes word 2**ADDR_WIDTH-1, so a fill takes exactly 2**ADDR_WIDTH cycles; clr_addr wraps to 0.
REQ-027 SHALL let reads already in the READ_LATENCY pipeline at entry to ST_CLEAR complete with their originally fetched data.

Reset
REQ-028 SHALL, while reset_n = 0, asynchronously set the following; RAM contents are not reset:
- state = ST_CLEAR if CLEAR_ON_RESET else ST_IDLE;
- clr_addr = 0;
- bus_rdata = 0 and bus_rdata_en = 0;
- all read pipeline stages cleared.
REQ-029 SHALL, on reset asserted mid-fill or mid-read, discard all in-flight reads and restart the fill from word 0 after release when CLEAR_ON_RESET = 1.

Structure
REQ-030 SHALL place the FSM state encodings (ST_IDLE, ST_CLEAR) and the legal READ_LATENCY values as constants in the shared ip_ram_pkg package.
REQ-031 SHALL isolate the storage array in one sub-module, ip_ram_core: single write port, registered single read port, with no reset on the array so it infers block RAM.

Verification
REQ-032 SHALL cover reset fill: ADDR_WIDTH=4, CLEAR_ON_RESET=1, release reset -> busy=1 and bus_ready=0 for exactly 16 cycles; then reads of all 16 addresses return 0.
REQ-033 SHALL cover write/read at both latencies: write 0xABCDEF1 to address 5, then read address 5 at cycle N -> bus_rdata=0xABCDEF1 with bus_rdata_en=1 at N+1 (READ_LATENCY=1) or N+2 (READ_LATENCY=2), bus_rdata=0 otherwise.
REQ-034 SHALL cover read then write at the same address: address 3 holds 0x1, read at N, write 0x2 at N+1 -> read returns 0x1; a read at N+2 returns 0x2.
REQ-035 SHALL cover clear with an access in the same cycle: read of address 7 (0x55) plus clear_req in one cycle -> read returns 0x55, busy rises next cycle, a clear_req during the fill is ignored (fill lasts 16 cycles), and address 7 reads 0 afterwards.
REQ-036 SHALL cover dropped requests and reset mid-fill:
- bus_valid with a write during busy -> no write occurs.
- reset_n pulsed at fill cycle 9 -> fill restarts and lasts a full 16 cycles.
